equ1_grad: RTL and testbench



---
 rtl/equ1_pkg.sv | 14 +
 rtl/equ1_absdiff.sv | 28 ++
 rtl/equ1_grad.sv | 80 ++++++++
 tb/tb_equ1_grad.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/equ1_pkg.sv
// Shared widths and helpers for the equation-1 horizontal gradient datapath.
package equ1_pkg;

  localparam int PIX_W = 12;
  localparam int OUT_W = 17;

  // Magnitude of a two's-complement value; wide enough for the 2nd-derivative term.
  function automatic logic [PIX_W+2:0] abs_s(input logic signed [PIX_W+2:0] x);
    logic signed [PIX_W+2:0] n;
    n = -x;
    return x[PIX_W+2] ? n : x;
  endfunction

endpackage

// File: rtl/equ1_absdiff.sv
// Registered |a-b| of two unsigned pixels, loading only when ld is high.
module equ1_absdiff
  import equ1_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] y_q
);

  logic signed [PIX_W:0] diff_s;
  logic [PIX_W-1:0]      y_d;

  always_comb begin
    diff_s = $signed({1'b0, a}) - $signed({1'b0, b});
    y_d    = y_q;
    // |a-b| of two unsigned PIX_W values always fits back into PIX_W bits.
    if (ld) y_d = PIX_W'(abs_s({{2{diff_s[PIX_W]}}, diff_s}));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) y_q <= '0;
    else      y_q <= y_d;
  end

endmodule

// File: rtl/equ1_grad.sv
// Equation-1 gradient: 2*|e3t2-e3t4| + |2*e3t3-e3t1-e3t5| + |e2t2-e2t4| + |e4t2-e4t4|.
// Define EQU1_OUT_REG_EN to add a registered output stage (latency 3 instead of 2).
module equ1_grad
  import equ1_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PIX_W-1:0] e1t1, e1t2, e1t3, e1t4, e1t5,
  input  logic [PIX_W-1:0] e2t1, e2t2, e2t3, e2t4, e2t5,
  input  logic [PIX_W-1:0] e3t1, e3t2, e3t3, e3t4, e3t5,
  input  logic [PIX_W-1:0] e4t1, e4t2, e4t3, e4t4, e4t5,
  input  logic [PIX_W-1:0] e5t1, e5t2, e5t3, e5t4, e5t5,
  output logic [OUT_W-1:0] grad_abs_out
);

`ifdef EQU1_OUT_REG_EN
  localparam int STAGES = 3;
`else
  localparam int STAGES = 2;
`endif

  logic [STAGES-1:1] vld_pipe_d, vld_pipe_q;
  logic [PIX_W-1:0]  r2_abs_q, r3_abs_q, r4_abs_q;
  logic signed [PIX_W+2:0] d2_s;
  logic [PIX_W:0]    d2_abs_d, d2_abs_q;
  logic [OUT_W-1:0]  sum_d, sum_q;
  logic [OUT_W-1:0]  out_d, out_q;

  // Window pixels that do not take part in equation 1.
  logic unused_pix;
  assign unused_pix = ^{e1t1, e1t2, e1t3, e1t4, e1t5, e2t1, e2t3, e2t5,
                        e4t1, e4t3, e4t5, e5t1, e5t2, e5t3, e5t4, e5t5};

  equ1_absdiff u_row2 (.clk(clk), .rst(rst), .ld(start), .a(e2t2), .b(e2t4), .y_q(r2_abs_q));
  equ1_absdiff u_row3 (.clk(clk), .rst(rst), .ld(start), .a(e3t2), .b(e3t4), .y_q(r3_abs_q));
  equ1_absdiff u_row4 (.clk(clk), .rst(rst), .ld(start), .a(e4t2), .b(e4t4), .y_q(r4_abs_q));

  always_comb begin
    vld_pipe_d = (STAGES-1)'({vld_pipe_q, start});
    d2_s       = $signed({2'b0, e3t3, 1'b0}) - $signed({3'b0, e3t1}) - $signed({3'b0, e3t5});
    d2_abs_d   = start ? (PIX_W+1)'(abs_s(d2_s)) : d2_abs_q;
    // Max sum is 24570, so no saturation is needed at OUT_W bits.
    sum_d      = OUT_W'({r3_abs_q, 1'b0}) + OUT_W'(d2_abs_q) + OUT_W'(r2_abs_q) + OUT_W'(r4_abs_q);
  end

`ifdef EQU1_OUT_REG_EN
  logic [OUT_W-1:0] sum_reg_d;

  always_comb begin
    sum_reg_d = vld_pipe_q[1] ? sum_d : sum_q;
    out_d     = vld_pipe_q[STAGES-1] ? sum_q : out_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sum_q <= '0;
    else      sum_q <= sum_reg_d;
  end
`else
  always_comb begin
    out_d = vld_pipe_q[STAGES-1] ? sum_d : out_q;
    sum_q = sum_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      d2_abs_q   <= '0;
      out_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      d2_abs_q   <= d2_abs_d;
      out_q      <= out_d;
    end
  end

  assign grad_abs_out = out_q;

endmodule

// File: tb/tb_equ1_grad.sv
// Self-checking bench for equ1_grad: directed corner windows plus randomized streaming and resets.
module tb_equ1_grad;

`ifdef EQU1_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] pix [1:5][1:5];
  logic [16:0] grad_abs_out;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  equ1_grad dut (
    .clk(clk), .rst(rst), .start(start),
    .e1t1(pix[1][1]), .e1t2(pix[1][2]), .e1t3(pix[1][3]), .e1t4(pix[1][4]), .e1t5(pix[1][5]),
    .e2t1(pix[2][1]), .e2t2(pix[2][2]), .e2t3(pix[2][3]), .e2t4(pix[2][4]), .e2t5(pix[2][5]),
    .e3t1(pix[3][1]), .e3t2(pix[3][2]), .e3t3(pix[3][3]), .e3t4(pix[3][4]), .e3t5(pix[3][5]),
    .e4t1(pix[4][1]), .e4t2(pix[4][2]), .e4t3(pix[4][3]), .e4t4(pix[4][4]), .e4t5(pix[4][5]),
    .e5t1(pix[5][1]), .e5t2(pix[5][2]), .e5t3(pix[5][3]), .e5t4(pix[5][4]), .e5t5(pix[5][5]),
    .grad_abs_out(grad_abs_out)
  );

  // Reference: gradient formula in plain integers, results released LAT-1 edges after sampling.
  typedef struct { int due; int val; } pend_t;
  pend_t pend[$];
  int    exp_out = 0;
  int    cyc = 0;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int model_g();
    return 2 * iabs(int'(pix[3][2]) - int'(pix[3][4]))
         + iabs(2 * int'(pix[3][3]) - int'(pix[3][1]) - int'(pix[3][5]))
         + iabs(int'(pix[2][2]) - int'(pix[2][4]))
         + iabs(int'(pix[4][2]) - int'(pix[4][4]));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend.delete();
      exp_out = 0;
    end else begin
      cyc++;
      while (pend.size() > 0 && pend[0].due == cyc) begin
        exp_out = pend[0].val;
        void'(pend.pop_front());
      end
      if (start) pend.push_back('{due: cyc + LAT - 1, val: model_g()});
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input string tag);
    @(negedge clk);
    chk(tag, int'(grad_abs_out), exp_out);
  endtask

  task automatic set_all(input int v);
    for (int r = 1; r <= 5; r++)
      for (int c = 1; c <= 5; c++) pix[r][c] = 12'(v);
  endtask

  task automatic set_ramp();
    for (int r = 1; r <= 5; r++)
      for (int c = 1; c <= 5; c++) pix[r][c] = 12'(10 * c);
  endtask

  task automatic set_spike();
    set_all(0);
    pix[3][3] = 12'd4095;
  endtask

  task automatic set_full();
    set_all(0);
    pix[3][2] = 12'd4095; pix[3][3] = 12'd4095; pix[2][2] = 12'd4095; pix[4][2] = 12'd4095;
  endtask

  task automatic set_rand();
    for (int r = 1; r <= 5; r++)
      for (int c = 1; c <= 5; c++)
        case ($urandom_range(0, 5))
          0:       pix[r][c] = 12'd0;
          1:       pix[r][c] = 12'd4095;
          default: pix[r][c] = 12'($urandom);
        endcase
  endtask

  // Drives one window for a single cycle, then idles long enough for it to drain.
  task automatic one_window(input string tag, input int expect_val);
    start = 1'b1;
    tick(tag);
    start = 1'b0;
    set_all(0);
    for (int i = 0; i < LAT; i++) tick(tag);
    chk({tag, "_abs"}, int'(grad_abs_out), expect_val);
  endtask

  initial begin
    set_all(0);
    #1;
    chk("reset_out", int'(grad_abs_out), 0);
    repeat (2) tick("reset");
    rst = 1'b1;
    tick("idle");

    set_all(0);   one_window("zero", 0);
    set_all(100); one_window("flat", 0);
    set_spike();  one_window("spike", 8190);
    set_full();   one_window("full", 24570);
    set_ramp();   one_window("ramp", 80);

    // Back-to-back windows, then a long idle stretch that must hold the last result.
    start = 1'b1;
    set_spike(); tick("stream");
    set_ramp();  tick("stream");
    set_all(0);  tick("stream");
    start = 1'b0;
    set_all(4095);
    for (int i = 0; i < 10 + LAT; i++) tick("hold");
    chk("hold_abs", int'(grad_abs_out), 0);

    // Reset while a spike is in flight: it must never reach the output.
    set_spike(); start = 1'b1;
    tick("pre_rst");
    start = 1'b0; set_all(0);
    rst = 1'b0;
    #1;
    chk("rst_async", int'(grad_abs_out), 0);
    for (int i = 0; i < LAT + 1; i++) tick("in_rst");
    rst = 1'b1;
    set_ramp(); one_window("post_rst", 80);

    // Randomized streaming with sporadic holds and resets.
    for (int n = 0; n < 400; n++) begin
      start = ($urandom_range(0, 3) != 0);
      set_rand();
      if ($urandom_range(0, 99) == 0) rst = 1'b0;
      tick("rand");
      rst = 1'b1;
    end
    start = 1'b0;
    for (int i = 0; i < LAT + 1; i++) tick("drain");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
